dmem_arbiter: RTL

Two-port arbiter and sequencer that shares the single-ported data memory between two requesters. Port 0 is the core load/store path and port 1 is a debug or DMA loader. The memory has a combinational read and a write on the clock edge. The block accepts word requests, drives the memory for exactly one cycle, registers the read data, and returns a one-cycle ack with error status. It sits between the requesters and the data memory.

---
 rtl/dmem_arbiter_pkg.sv | 22 ++
 rtl/dmem_arbiter_if.sv | 28 ++
 rtl/dmem_arbiter_rr_pick2.sv | 21 ++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int NUM_PORTS     = 2;
    localparam int DEF_MEM_WORDS = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    // An access is rejected when it is not word aligned or falls past the
    // end of the attached memory. The address is widened so any AW fits.
    function automatic logic addr_err(input logic [63:0] addr,
                                      input int unsigned mem_words);
        logic [63:0] limit;
        limit = 64'(mem_words) << 2;
        return (addr[1:0] != 2'b00) || (addr >= limit);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: both ports' request
// signals plus the shared response.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32
);

    logic [NUM_PORTS-1:0]    req;
    logic [NUM_PORTS-1:0]    we;
    logic [NUM_PORTS*AW-1:0] addr;
    logic [NUM_PORTS*DW-1:0] wdata;
    logic [NUM_PORTS-1:0]    ack;
    logic [NUM_PORTS-1:0]    err;
    logic [DW-1:0]           rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, err, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, err, rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker. On a tie the port that was not
// served last wins.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       rr_last_i,
    output logic       valid_o,
    output logic       winner_o
);

    // Single requester wins outright; a tie goes to the other port.
    always_comb begin
        valid_o  = |req_i;
        winner_o = 1'b0;
        if (req_i == 2'b11) begin
            winner_o = ~rr_last_i;
        end else begin
            winner_o = req_i[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-ported data memory between the core port (0) and a
// debug/DMA port (1). Each request gets one memory cycle, then a one-cycle
// ack with registered read data and an error flag.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no access in flight; arbitrate on raw req
// ST_ACCESS | latched command drives the memory for this single cycle
// ST_RESP   | ack/err to owner; arbitrate on req with owner masked off
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_WORDS = DEF_MEM_WORDS,
    parameter int DW        = 32,
    parameter int AW        = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wd,
    output logic           mem_we,
    input  logic [DW-1:0]  mem_rd
);

    arb_state_t    state_q, state_d;
    logic          owner_q, owner_d;
    logic          rr_last_q, rr_last_d;
    logic          cmd_we_q, cmd_we_d;
    logic          cmd_err_q, cmd_err_d;
    logic [AW-1:0] cmd_addr_q, cmd_addr_d;
    logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [1:0]    pick_req;
    logic          pick_valid;
    logic          pick_win;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // The owner still holds req during its ack cycle, so it is masked out
    // to keep it from being served twice.
    assign pick_req = (state_q == ST_RESP) ? (bus.req & ~(2'b01 << owner_q))
                                           : bus.req;

    rr_pick2 u_pick (
        .req_i     (pick_req),
        .rr_last_i (rr_last_q),
        .valid_o   (pick_valid),
        .winner_o  (pick_win)
    );

    assign win_we    = pick_win ? bus.we[1] : bus.we[0];
    assign win_addr  = pick_win ? bus.addr[2*AW-1:AW]  : bus.addr[AW-1:0];
    assign win_wdata = pick_win ? bus.wdata[2*DW-1:DW] : bus.wdata[DW-1:0];

    // State register and command/response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            rr_last_q   <= 1'b1;
            cmd_we_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_last_q   <= rr_last_d;
            cmd_we_q    <= cmd_we_d;
            cmd_err_q   <= cmd_err_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // Next-state logic: latch a winner from IDLE or RESP, capture read data in ACCESS.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_last_d   = rr_last_q;
        cmd_we_d    = cmd_we_q;
        cmd_err_d   = cmd_err_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rdata_d     = rdata_q;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (pick_valid) begin
                    state_d     = ST_ACCESS;
                    owner_d     = pick_win;
                    rr_last_d   = pick_win;
                    cmd_we_d    = win_we;
                    cmd_addr_d  = win_addr;
                    cmd_wdata_d = win_wdata;
                    cmd_err_d   = addr_err(64'(win_addr), MEM_WORDS);
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                rdata_d = (!cmd_we_q && !cmd_err_q) ? mem_rd : '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory drive comes straight from the command registers; the write
    // strobe is decoded from state so reset kills it immediately.
    assign mem_addr = cmd_addr_q;
    assign mem_wd   = cmd_wdata_q;
    assign mem_we   = (state_q == ST_ACCESS) && cmd_we_q && !cmd_err_q;

    assign bus.ack   = (state_q == ST_RESP) ? (2'b01 << owner_q) : 2'b00;
    assign bus.err   = (state_q == ST_RESP && cmd_err_q) ? (2'b01 << owner_q) : 2'b00;
    assign bus.rdata = rdata_q;

endmodule
